// File: rtl/monitor_decodificador.sv
// Checks a captured 2-to-4 decoder sample (one-hot Y plus derived f2/f3), re-encodes
// the active line onto S1/S0 and counts legal samples; illegal samples park in ERRO.
module monitor_decodificador (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Y0,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       Y3,
  input  logic       f2,
  input  logic       f3,
  input  logic       amostra,
  input  logic       limpar,
  output logic       S1,
  output logic       S0,
  output logic       valido,
  output logic       ocupado,
  output logic       erro,
  output logic [3:0] cnt_amostras,
  output logic [3:0] cnt_f3
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VERIFICA = 2'd1,
    ERRO     = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] y_q;
  logic       f2_q;
  logic       f3_q;
  logic [1:0] s_q;
  logic       valido_q;
  logic [3:0] cnt_am_q;
  logic [3:0] cnt_f3_q;

  logic       onehot_d;
  logic       legal_d;
  logic [1:0] enc_d;

  // Legality and encoding are judged only from the captured copy, so input
  // activity during VERIFICA cannot influence the outcome.
  always_comb begin
    onehot_d = 1'b0;
    enc_d    = 2'b00;
    case (y_q)
      4'b0001: begin onehot_d = 1'b1; enc_d = 2'b00; end
      4'b0010: begin onehot_d = 1'b1; enc_d = 2'b01; end
      4'b0100: begin onehot_d = 1'b1; enc_d = 2'b10; end
      4'b1000: begin onehot_d = 1'b1; enc_d = 2'b11; end
      default: begin onehot_d = 1'b0; enc_d = 2'b00; end
    endcase
    legal_d = onehot_d
            & (f2_q == (y_q[0] | y_q[2]))
            & (~f3_q | y_q[1] | y_q[2]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= OCIOSO;
      y_q      <= 4'b0000;
      f2_q     <= 1'b0;
      f3_q     <= 1'b0;
      s_q      <= 2'b00;
      valido_q <= 1'b0;
      cnt_am_q <= 4'd0;
      cnt_f3_q <= 4'd0;
    end else begin
      valido_q <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (amostra) begin
            y_q     <= {Y3, Y2, Y1, Y0};
            f2_q    <= f2;
            f3_q    <= f3;
            state_q <= VERIFICA;
          end
        end
        VERIFICA: begin
          if (legal_d) begin
            s_q      <= enc_d;
            valido_q <= 1'b1;
            cnt_am_q <= cnt_am_q + 4'd1;
            if (f3_q && (cnt_f3_q != 4'd15)) cnt_f3_q <= cnt_f3_q + 4'd1;
            state_q  <= OCIOSO;
          end else begin
            state_q  <= ERRO;
          end
        end
        ERRO: begin
          // Clearing wins over a simultaneous strobe; no capture on this edge.
          if (limpar) state_q <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign S1           = s_q[1];
  assign S0           = s_q[0];
  assign valido       = valido_q;
  assign ocupado      = (state_q != OCIOSO);
  assign erro         = (state_q == ERRO);
  assign cnt_amostras = cnt_am_q;
  assign cnt_f3       = cnt_f3_q;

endmodule

// File: tb/tb_monitor_decodificador.sv
// Directed bench for monitor_decodificador; expected output words are hand-derived.
module tb_monitor_decodificador;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Y0 = 0, Y1 = 0, Y2 = 0, Y3 = 0, f2 = 0, f3 = 0;
  logic       amostra = 0, limpar = 0;
  logic       S1, S0, valido, ocupado, erro;
  logic [3:0] cnt_amostras, cnt_f3;

  int passed = 0;
  int total  = 0;
  int pulses;

  monitor_decodificador dut (
    .clk(clk), .rst_n(rst_n),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .f2(f2), .f3(f3),
    .amostra(amostra), .limpar(limpar),
    .S1(S1), .S0(S0), .valido(valido), .ocupado(ocupado), .erro(erro),
    .cnt_amostras(cnt_amostras), .cnt_f3(cnt_f3)
  );

  always #5 clk = ~clk;

  // Observed word: {S1,S0,valido,ocupado,erro,cnt_amostras,cnt_f3}
  function automatic logic [12:0] outs();
    return {S1, S0, valido, ocupado, erro, cnt_amostras, cnt_f3};
  endfunction

  function automatic logic [12:0] ex(input logic [1:0] s, input logic v, input logic oc,
                                     input logic er, input logic [3:0] ca, input logic [3:0] cf);
    return {s, v, oc, er, ca, cf};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input logic [3:0] y, input logic nf2, input logic nf3);
    {Y3, Y2, Y1, Y0} = y;
    f2 = nf2;
    f3 = nf3;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));
    rst_n = 1;
    tick();
    chk("idle_hold", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));

    // Legal Y2 sample; inputs scrambled and limpar raised while verifying
    set_y(4'b0100, 1, 1); amostra = 1;
    tick();
    chk("y2_verifica", outs(), ex(2'b00, 0, 1, 0, 4'd0, 4'd0));
    amostra = 0; set_y(4'b0011, 0, 1); limpar = 1;
    tick();
    chk("y2_update", outs(), ex(2'b10, 1, 0, 0, 4'd1, 4'd1));
    limpar = 0;
    tick();
    chk("y2_pulse_end", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));

    // Illegal one-hot Y0=Y1
    set_y(4'b0011, 1, 0); amostra = 1;
    tick(); amostra = 0;
    tick();
    chk("onehot_erro", outs(), ex(2'b10, 0, 1, 1, 4'd1, 4'd1));
    set_y(4'b0001, 1, 0); amostra = 1;
    tick(); tick();
    chk("erro_ignores_amostra", outs(), ex(2'b10, 0, 1, 1, 4'd1, 4'd1));
    limpar = 1;
    tick();
    chk("limpar_with_amostra", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));
    limpar = 0; amostra = 0;
    tick();
    chk("no_capture_on_clear", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));

    // limpar in OCIOSO does nothing
    limpar = 1;
    tick();
    chk("limpar_idle", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));
    limpar = 0;

    // f2 inconsistency: Y3 with f2=1
    set_y(4'b1000, 1, 0); amostra = 1;
    tick(); amostra = 0;
    tick();
    chk("f2_bad", outs(), ex(2'b10, 0, 1, 1, 4'd1, 4'd1));
    limpar = 1; tick(); limpar = 0;
    chk("f2_bad_clear", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));

    // f3 inconsistency: Y0 with f3=1
    set_y(4'b0001, 1, 1); amostra = 1;
    tick(); amostra = 0;
    tick();
    chk("f3_bad", outs(), ex(2'b10, 0, 1, 1, 4'd1, 4'd1));
    limpar = 1; tick(); limpar = 0;
    chk("f3_bad_clear", outs(), ex(2'b10, 0, 0, 0, 4'd1, 4'd1));

    // Reset in ERRO
    set_y(4'b0000, 0, 0); amostra = 1;
    tick(); amostra = 0; tick();
    chk("pre_reset_erro", outs(), ex(2'b10, 0, 1, 1, 4'd1, 4'd1));
    rst_n = 0; tick(); rst_n = 1;
    chk("reset_from_erro", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));

    // amostra held 6 cycles, legal Y0
    set_y(4'b0001, 1, 0); amostra = 1; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valido) pulses++;
    end
    amostra = 0;
    chk("held_pulses", 13'(pulses), 13'd3);
    tick();
    chk("held_final", outs(), ex(2'b00, 0, 0, 0, 4'd3, 4'd0));

    // 17 legal Y1, f3=1 samples from reset: wrap and saturation
    rst_n = 0; tick(); rst_n = 1;
    set_y(4'b0010, 0, 1);
    for (int i = 0; i < 17; i++) begin
      amostra = 1; tick(); amostra = 0; tick();
      if (i == 14) chk("cnt_15", outs(), ex(2'b01, 1, 0, 0, 4'd15, 4'd15));
      if (i == 15) chk("cnt_wrap0", outs(), ex(2'b01, 1, 0, 0, 4'd0, 4'd15));
    end
    chk("cnt_17", outs(), ex(2'b01, 1, 0, 0, 4'd1, 4'd15));

    // Reset mid-VERIFICA suppresses the pulse
    set_y(4'b0100, 1, 0); amostra = 1;
    tick(); amostra = 0;
    chk("mid_verifica", outs(), ex(2'b01, 0, 1, 0, 4'd1, 4'd15));
    rst_n = 0; tick(); rst_n = 1;
    chk("reset_mid_verifica", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));
    tick();
    chk("no_late_pulse", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));

    // Reset wins over amostra
    amostra = 1; rst_n = 0; tick(); rst_n = 1; amostra = 0;
    chk("reset_priority", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));
    tick();
    chk("reset_priority_idle", outs(), ex(2'b00, 0, 0, 0, 4'd0, 4'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
